mux_rr_arb: RTL

MUX_RR_ARB -- requirements
Module: mux_rr_arb

---
 rtl/mux_rr_arb_pkg.sv | 15 +
 rtl/mux_rr_arb_rr_grant.sv | 33 +++
 rtl/mux_rr_arb.sv | 88 ++++++++
 3 files changed

// File: rtl/mux_rr_arb_pkg.sv
// Shared arbitration-mode encodings and select-width helper for the mux/arbiter family.
package mux_rr_arb_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Bits needed to index n channels, never less than one.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_grant.sv
// One-hot grant over a request vector: rotating scan from ptr, or fixed lowest-index priority.
module rr_grant
  import mux_rr_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant
);

  logic [SW-1:0] start;
  logic [SW-1:0] idx;
  logic          found;

  // Fixed priority is a rotating scan that always starts at channel 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    start = mode ? '0 : ptr;
    for (int i = 0; i < N; i++) begin
      idx = SW'((int'(start) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready arbiter-mux with a single registered output stage.
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned SW  = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]  grant;
  logic [SW-1:0] gnt_idx;
  logic          load_en;
  logic          load;

  logic [W-1:0]  out_data_d,  out_data_q;
  logic [SW-1:0] out_sel_d,   out_sel_q;
  logic          out_valid_d, out_valid_q;
  logic [SW-1:0] rr_ptr_d,    rr_ptr_q;

  rr_grant #(
    .N  (N),
    .SW (SW)
  ) u_grant (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .mode  (MODE == MODE_FIXED),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gnt_idx = SW'(i);
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign load    = load_en && (|grant);
  // Held-in-reset must not advertise acceptance even though the output stage looks empty.
  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_data_d  = in_data[int'(gnt_idx)*W +: W];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
